// File: rtl/shift_reg_serializer_if.sv
// Load handshake and serial-side signals of shift_reg_serializer.
// master = word source / link side, slave = the serializer itself.
interface shift_reg_serializer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       control;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             out;
  logic             busy;
  logic             word_done;

  modport master (
    output control, load_valid, load_data,
    input  load_ready, out, busy, word_done
  );

  modport slave (
    input  control, load_valid, load_data,
    output load_ready, out, busy, word_done
  );
endinterface

// File: rtl/shift_reg_serializer.sv
// Parallel-in/serial-out transmitter sharing the receiver's live control encoding.
// Optional even-parity trailer bit enabled by defining SHIFT_REG_SERIALIZER_PARITY_EN.
module shift_reg_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  shift_reg_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             word_done_q;
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  logic shift_en;
  logic last_data_shift;
  logic final_shift;
  logic ready;
  logic accept;
  logic out_bit;

  // The final shift frees the register in the same cycle so a new word can follow with no gap.
  always_comb begin
    shift_en        = (state != IDLE) && (bus.control != 2'b00);
    last_data_shift = (state == SHIFT) && shift_en && (cnt == CW'(WIDTH - 1));
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
    final_shift     = (state == PARITY) && shift_en;
`else
    final_shift     = last_data_shift;
`endif
    ready           = (state == IDLE) || final_shift;
    accept          = bus.load_valid && ready;
  end

  always_comb begin
    out_bit = 1'b0;
    case (state)
      IDLE:    out_bit = 1'b0;
      SHIFT:   out_bit = bus.control[0] ? shreg[0] : shreg[WIDTH-1];
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
      PARITY:  out_bit = parity_q;
`endif
      default: out_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      word_done_q <= 1'b0;
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      word_done_q <= final_shift;
      if (accept) begin
        shreg <= bus.load_data;
        cnt   <= '0;
        state <= SHIFT;
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
        parity_q <= ^bus.load_data;
`endif
      end else if (shift_en) begin
        case (state)
          SHIFT: begin
            // Zero fill: a later reversal of direction drains these zeros first.
            shreg <= bus.control[0] ? {1'b0, shreg[WIDTH-1:1]}
                                    : {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
            if (last_data_shift) begin
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
          PARITY:  state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.load_ready = ready;
  assign bus.out        = out_bit;
  assign bus.busy       = (state != IDLE);
  assign bus.word_done  = word_done_q;

endmodule

// File: tb/tb_shift_reg_serializer.sv
// Self-checking bench for shift_reg_serializer: directed scenarios plus randomized
// traffic compared against a bit-queue model of the transmitted word.
module tb_shift_reg_serializer;

  localparam int WIDTH = 8;
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = WIDTH + PAR;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  shift_reg_serializer_if #(.WIDTH(WIDTH)) bus ();

  shift_reg_serializer #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: remaining word bits as a deque (front = LSB end, back = MSB end).
  bit mq[$];
  int m_sent;
  bit m_active;
  bit m_par;
  bit m_done;

  function automatic void m_reset();
    mq.delete();
    m_sent   = 0;
    m_active = 0;
    m_par    = 0;
    m_done   = 0;
  endfunction

  function automatic void m_load(logic [WIDTH-1:0] d);
    mq.delete();
    for (int i = 0; i < WIDTH; i++) mq.push_back(d[i]);
    m_par    = ^d;
    m_sent   = 0;
    m_active = 1;
  endfunction

  function automatic bit m_final(logic [1:0] c);
    return m_active && (c != 2'b00) && (m_sent == NB - 1);
  endfunction

  function automatic bit m_ready(logic [1:0] c);
    return !m_active || m_final(c);
  endfunction

  function automatic bit m_out(logic [1:0] c);
    if (!m_active) return 1'b0;
    if (m_sent >= WIDTH) return m_par;
    return c[0] ? mq[0] : mq[mq.size()-1];
  endfunction

  function automatic void m_edge(logic [1:0] c, logic lv, logic [WIDTH-1:0] d);
    bit fin;
    bit acc;
    fin    = m_final(c);
    acc    = lv && m_ready(c);
    m_done = fin;
    if (acc) begin
      m_load(d);
    end else if (m_active && c != 2'b00) begin
      if (m_sent < WIDTH) begin
        if (c[0]) begin
          void'(mq.pop_front());
          mq.push_back(1'b0);
        end else begin
          void'(mq.pop_back());
          mq.push_front(1'b0);
        end
      end
      m_sent++;
      if (fin) m_active = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    m_edge(bus.control, bus.load_valid, bus.load_data);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.control    = 2'b01;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5A;
    m_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++; if (bus.out !== 1'b0) begin errors++; $display("[TB] FAIL reset_out: got %b expected 0", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.word_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_word_done: got %b expected 0", bus.word_done); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_ready: got %b expected 1", bus.load_ready); end
    @(negedge clock);
    bus.load_valid = 1'b0;
    reset_n        = 1'b1;
    tick();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    bit exp;
    int dones;
    pat = 8'hA5;
    dones = 0;
    bus.control = 2'b01; bus.load_valid = 1'b1; bus.load_data = pat;
    #1;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL lsb_ready_idle: got %b expected 1", bus.load_ready); end
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      exp = (i < WIDTH) ? pat[i] : 1'b0;
      checks++; if (bus.out !== exp) begin errors++; $display("[TB] FAIL lsb_out bit %0d: got %b expected %b", i, bus.out, exp); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL lsb_busy bit %0d: got %b expected 1", i, bus.busy); end
      if (bus.word_done === 1'b1) dones++;
      tick();
    end
    #1;
    if (bus.word_done === 1'b1) dones++;
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL lsb_word_done_count: got %0d expected 1", dones); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL lsb_busy_end: got %b expected 0", bus.busy); end
    tick();
  endtask

  task automatic test_msb_first();
    logic [7:0] pat;
    logic [7:0] rx;
    bit exp;
    pat = 8'hA5;
    rx  = '0;
    bus.control = 2'b10; bus.load_valid = 1'b1; bus.load_data = pat;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      exp = (i < WIDTH) ? pat[WIDTH-1-i] : 1'b0;
      checks++; if (bus.out !== exp) begin errors++; $display("[TB] FAIL msb_out bit %0d: got %b expected %b", i, bus.out, exp); end
      if (i < WIDTH) rx = {rx[6:0], bus.out};
      tick();
    end
    #1;
    checks++; if (rx !== pat) begin errors++; $display("[TB] FAIL msb_receiver_word: got %h expected %h", rx, pat); end
    checks++; if (bus.word_done !== 1'b1) begin errors++; $display("[TB] FAIL msb_word_done: got %b expected 1", bus.word_done); end
    tick();
  endtask

  task automatic test_hold();
    logic [7:0] pat;
    logic [7:0] rx;
    int dones;
    pat = 8'h3C;
    rx  = '0;
    dones = 0;
    bus.control = 2'b01; bus.load_valid = 1'b1; bus.load_data = pat;
    tick();
    bus.load_valid = 1'b0;
    for (int j = 0; j < 2 * NB; j++) begin
      bus.control = (j % 2 == 0) ? 2'b01 : 2'b00;
      #1;
      checks++; if (bus.out !== m_out(bus.control)) begin errors++; $display("[TB] FAIL hold_out cycle %0d: got %b expected %b", j, bus.out, m_out(bus.control)); end
      checks++; if (bus.load_ready !== m_ready(bus.control)) begin errors++; $display("[TB] FAIL hold_ready cycle %0d: got %b expected %b", j, bus.load_ready, m_ready(bus.control)); end
      checks++; if (bus.busy !== m_active) begin errors++; $display("[TB] FAIL hold_busy cycle %0d: got %b expected %b", j, bus.busy, m_active); end
      if (m_active) begin
        checks++; if (int'(dut.cnt) != m_sent) begin errors++; $display("[TB] FAIL hold_cnt cycle %0d: got %0d expected %0d", j, dut.cnt, m_sent); end
      end
      if (bus.control == 2'b01 && m_sent < WIDTH && m_active) rx = {bus.out, rx[7:1]};
      if (bus.word_done === 1'b1) dones++;
      tick();
    end
    #1;
    checks++; if (rx !== pat) begin errors++; $display("[TB] FAIL hold_receiver_word: got %h expected %h", rx, pat); end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL hold_word_done_count: got %0d expected 1", dones); end
    bus.control = 2'b01;
    tick();
  endtask

  task automatic test_back_to_back();
    int dones;
    int idle_cycles;
    dones = 0;
    idle_cycles = 0;
    bus.control = 2'b01; bus.load_valid = 1'b1; bus.load_data = 8'h11;
    tick();
    bus.load_data = 8'h22;
    for (int c = 0; c < 2 * NB; c++) begin
      #1;
      checks++; if (bus.load_ready !== m_ready(bus.control)) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d: got %b expected %b", c, bus.load_ready, m_ready(bus.control)); end
      checks++; if (bus.out !== m_out(bus.control)) begin errors++; $display("[TB] FAIL b2b_out cycle %0d: got %b expected %b", c, bus.out, m_out(bus.control)); end
      if (bus.busy !== 1'b1) idle_cycles++;
      if (bus.word_done === 1'b1) dones++;
      if (c == NB - 1) begin
        tick();
        bus.load_valid = 1'b0;
      end else begin
        tick();
      end
    end
    #1;
    if (bus.word_done === 1'b1) dones++;
    checks++; if (idle_cycles != 0) begin errors++; $display("[TB] FAIL b2b_gap: got %0d idle cycles expected 0", idle_cycles); end
    checks++; if (dones != 2) begin errors++; $display("[TB] FAIL b2b_word_done_count: got %0d expected 2", dones); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", bus.busy); end
    tick();
  endtask

  task automatic test_reset_mid_word();
    bus.control = 2'b01; bus.load_valid = 1'b1; bus.load_data = 8'hFF;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.control = 2'b10;
    reset_n = 1'b0;
    bus.load_valid = 1'b1;
    #1;
    m_reset();
    checks++; if (bus.out !== 1'b0) begin errors++; $display("[TB] FAIL abort_out: got %b expected 0", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.word_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_word_done: got %b expected 0", bus.word_done); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_load_ready: got %b expected 1", bus.load_ready); end
    @(negedge clock);
    @(negedge clock);
    bus.load_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    #1;
    checks++; if (bus.word_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %b expected 0", bus.word_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy_after: got %b expected 0", bus.busy); end
  endtask

`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
  task automatic test_parity();
    bus.control = 2'b10; bus.load_valid = 1'b1; bus.load_data = 8'h07;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) tick();
    bus.control = 2'b01;
    #1;
    checks++; if (bus.out !== 1'b1) begin errors++; $display("[TB] FAIL parity_bit: got %b expected 1", bus.out); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL parity_ready: got %b expected 1", bus.load_ready); end
    tick();
    #1;
    checks++; if (bus.word_done !== 1'b1) begin errors++; $display("[TB] FAIL parity_word_done: got %b expected 1", bus.word_done); end
    tick();
  endtask
`endif

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 3);
      bus.control    = (r == 0) ? 2'b00 : 2'(r);
      bus.load_valid = ($urandom_range(0, 1) == 1);
      bus.load_data  = WIDTH'($urandom);
      #1;
      checks++; if (bus.out !== m_out(bus.control)) begin errors++; $display("[TB] FAIL rand_out cycle %0d: got %b expected %b", cyc, bus.out, m_out(bus.control)); end
      checks++; if (bus.load_ready !== m_ready(bus.control)) begin errors++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", cyc, bus.load_ready, m_ready(bus.control)); end
      checks++; if (bus.busy !== m_active) begin errors++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", cyc, bus.busy, m_active); end
      checks++; if (bus.word_done !== m_done) begin errors++; $display("[TB] FAIL rand_word_done cycle %0d: got %b expected %b", cyc, bus.word_done, m_done); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.control    = 2'b00;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    m_reset();
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_hold();
    test_back_to_back();
    test_reset_mid_word();
`ifdef SHIFT_REG_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_serializer.md
# shift_reg_serializer

Parallel-in/serial-out companion to the serial-in shift register receiver: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per enabled cycle on `out`. It obeys the same live `control[1:0]` encoding as the receiver: shift right sends LSB first, shift left sends MSB first, 00 holds. Driving both ends with the same `control` stream therefore reconstructs the word unchanged in the receiver. It sits on the transmit side of the serial link, between the word source and the pin.

## Interface
- `WIDTH`, 8, data word width in bits (≥2)
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `control`  in  2  live shift command: [0]=shift right (LSB out), else [1]=shift left (MSB out), 00=hold; [0] has priority
- `load_valid`  in  1  source offers `load_data`
- `load_data`  in  WIDTH  word to serialize
- `load_ready`  out  1  serializer can take a word this cycle
- `out`  out  1  serial bit presented this cycle
- `busy`  out  1  a word (or its parity bit) is being shifted
- `word_done`  out  1  one-cycle pulse after the final bit of a word shifts out

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- Accept = `load_valid & load_ready`. Words offered while `load_ready`=0 are ignored, not queued.
- On accept: `shreg` ← `load_data`; `cnt` ← 0; state ← SHIFT.
- In SHIFT:
  - A cycle with `control`≠00 is a shift.
  - `out` = `control[0] ? shreg[0] : shreg[WIDTH-1]`. This path is combinational from `control`.
  - Each shift moves `shreg` one place in the commanded direction, fills with 0, and increments `cnt`.
  - `control`=00 freezes `shreg`, `cnt` and state.
- Direction may change mid-word. Each shift takes the bit from whichever end `control` selects.
- Last shift is the shift with `cnt`=WIDTH-1. After it:
  - Without the macro: state ← IDLE, `word_done` pulses.
  - With the macro: state ← PARITY.
- `load_ready` = (state==IDLE) | (final shift of the word occurring this cycle). This allows back-to-back words with no gap.
- If a load is accepted on the final shift: the new word loads, state stays SHIFT, `cnt` ← 0, and `word_done` still pulses.
- In IDLE, `out` = 0 regardless of `control`. `busy` = (state≠IDLE).
- `cnt` is $clog2(WIDTH+1) bits wide. It never exceeds WIDTH.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE; `shreg`, `cnt`, parity register 0.
  - `out`=0, `busy`=0, `word_done`=0, `load_ready`=1.
- Accept at edge N: `busy`=1 from cycle N+1. First bit is valid on `out` in the first enabled cycle after N.
- A word takes exactly WIDTH enabled cycles (WIDTH+1 with parity), plus any hold cycles.
- `word_done` is registered and high for the single cycle after the edge that consumed the last bit.
- Reset mid-word: the word is discarded immediately and all outputs return to reset values. No `word_done`.
- `load_valid` during reset is ignored.

## Configuration
- `SHIFT_REG_SERIALIZER_PARITY_EN` defined:
  - At accept, even parity (XOR of `load_data`) is captured.
  - After the WIDTH data bits, PARITY state drives it on `out` for one enabled cycle, regardless of direction.
  - The final shift is then the parity shift: `word_done` and `load_ready` follow it.
- Undefined: no parity logic, no PARITY state, WIDTH bits per word.

## Test plan
- Reset, then load 8'hA5 with `control`=01 held: `out` sequence 1,0,1,0,0,1,0,1 (LSB first); `word_done` pulses once; `busy` returns 0.
- Load 8'hA5 with `control`=10: `out` sequence 1,0,1,0,0,1,0,1 (MSB first). Drive a receiver with the same `control`: it captures 8'hA5.
- Load 8'h3C with `control` alternating 01/00: 16 cycles total, 8 bits unchanged, `cnt` frozen on hold cycles.
- Hold `load_valid`=1 with words 8'h11 then 8'h22: second word is accepted on the final shift of the first; zero idle cycles between words; two `word_done` pulses.
- Assert `reset_n`=0 after 3 shifts: `out`, `busy`, `word_done` go 0 and `load_ready` goes 1 immediately, with no `word_done` for the aborted word. With the macro, 8'h07 appends parity bit 1 as the 9th bit.
